// File: rtl/iq_pkg.sv
// Shared types, default widths and output saturation for the IQ lock-in accumulator.
package iq_pkg;

    localparam int DEF_ADC_W = 14;
    localparam int DEF_REF_W = 16;
    localparam int DEF_ACC_W = 48;
    localparam int DEF_N_W   = 16;
    localparam int DEF_SHIFT = 16;
    localparam int DEF_OUT_W = 32;
    localparam int DEF_SAT_W = 26;

    typedef enum logic [2:0] {
        IDLE,
        ACUM,
        DRAIN,
        ESCALA,
        LANZA,
        FIN
    } state_t;

    typedef struct packed {
        logic                        clip;
        logic signed [DEF_SAT_W-1:0] val;
    } sat_t;

    localparam logic signed [DEF_ACC_W-1:0] SAT_MAX =
        {{(DEF_ACC_W-DEF_SAT_W+1){1'b0}}, {(DEF_SAT_W-1){1'b1}}};
    localparam logic signed [DEF_ACC_W-1:0] SAT_MIN =
        {{(DEF_ACC_W-DEF_SAT_W+1){1'b1}}, {(DEF_SAT_W-1){1'b0}}};

    // Clamp a scaled accumulator into the signed SAT_W range the arctan2 stage can take.
    function automatic sat_t saturate(input logic signed [DEF_ACC_W-1:0] x);
        sat_t r;
        if (x > SAT_MAX) begin
            r.clip = 1'b1;
            r.val  = SAT_MAX[DEF_SAT_W-1:0];
        end else if (x < SAT_MIN) begin
            r.clip = 1'b1;
            r.val  = SAT_MIN[DEF_SAT_W-1:0];
        end else begin
            r.clip = 1'b0;
            r.val  = x[DEF_SAT_W-1:0];
        end
        return r;
    endfunction

endpackage

// File: rtl/mac_canal.sv
// Two-stage multiply-accumulate channel: registered full-precision product, then
// sign-extended accumulation.
module mac_canal #(
    parameter int A_W   = 14,
    parameter int B_W   = 16,
    parameter int ACC_W = 48
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clr,
    input  logic                    en,
    input  logic signed [A_W-1:0]   a,
    input  logic signed [B_W-1:0]   b,
    output logic signed [ACC_W-1:0] acc
);

    localparam int P_W = A_W + B_W;

    logic signed [P_W-1:0]   prod_q, prod_d;
    logic                    vld_q, vld_d;
    logic signed [ACC_W-1:0] acc_q, acc_d;

    always_comb begin
        prod_d = prod_q;
        vld_d  = en && !clr;
        acc_d  = acc_q;
        if (en) begin
            prod_d = P_W'(a) * P_W'(b);
        end
        if (clr) begin
            acc_d = '0;
        end else if (vld_q) begin
            acc_d = acc_q + {{(ACC_W-P_W){prod_q[P_W-1]}}, prod_q};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prod_q <= '0;
            vld_q  <= 1'b0;
            acc_q  <= '0;
        end else begin
            prod_q <= prod_d;
            vld_q  <= vld_d;
            acc_q  <= acc_d;
        end
    end

    assign acc = acc_q;

endmodule

// File: rtl/iq_acumulador.sv
// Lock-in I/Q accumulator feeding the arctan2 phase divider: sample counting,
// scaling/saturation and the Start/Done handshake.
//
// state  | meaning
// IDLE   | waiting for Meas_start with a non-zero sample count
// ACUM   | accepting samples until the latched count is reached
// DRAIN  | last product settles into the accumulators
// ESCALA | shift, saturate and register I/Q outputs
// LANZA  | Atan_start held until Atan_done
// FIN    | one-cycle Ready pulse
module iq_acumulador
    import iq_pkg::*;
#(
    parameter int ADC_W = DEF_ADC_W,
    parameter int REF_W = DEF_REF_W,
    parameter int ACC_W = DEF_ACC_W,
    parameter int N_W   = DEF_N_W,
    parameter int SHIFT = DEF_SHIFT,
    parameter int OUT_W = DEF_OUT_W,
    parameter int SAT_W = DEF_SAT_W
) (
    input  logic                    CLK,
    input  logic                    RSTa,
    input  logic                    Meas_start,
    input  logic [N_W-1:0]          N_samples,
    input  logic                    Sample_valid,
    input  logic signed [ADC_W-1:0] Adc,
    input  logic signed [REF_W-1:0] Ref_sin,
    input  logic signed [REF_W-1:0] Ref_cos,
    input  logic                    Atan_done,
    output logic signed [OUT_W-1:0] Q_out,
    output logic signed [OUT_W-1:0] I_out,
    output logic                    Atan_start,
    output logic                    Busy,
    output logic                    Ready,
    output logic                    Sat
);

    state_t                  state_q, state_d;
    logic [N_W-1:0]          n_q, n_d;
    logic [N_W-1:0]          cnt_q, cnt_d;
    logic                    sat_q, sat_d;
    logic signed [OUT_W-1:0] i_q, i_d;
    logic signed [OUT_W-1:0] q_q, q_d;

    logic                    acc_clr;
    logic                    accept;
    logic signed [ACC_W-1:0] acc_i, acc_q;
    sat_t                    sat_i, sat_q_ch;

    mac_canal #(
        .A_W   (ADC_W),
        .B_W   (REF_W),
        .ACC_W (ACC_W)
    ) u_mac_i (
        .clk   (CLK),
        .rst_n (RSTa),
        .clr   (acc_clr),
        .en    (accept),
        .a     (Adc),
        .b     (Ref_cos),
        .acc   (acc_i)
    );

    mac_canal #(
        .A_W   (ADC_W),
        .B_W   (REF_W),
        .ACC_W (ACC_W)
    ) u_mac_q (
        .clk   (CLK),
        .rst_n (RSTa),
        .clr   (acc_clr),
        .en    (accept),
        .a     (Adc),
        .b     (Ref_sin),
        .acc   (acc_q)
    );

    assign sat_i    = saturate(acc_i >>> SHIFT);
    assign sat_q_ch = saturate(acc_q >>> SHIFT);

    always_comb begin
        state_d = state_q;
        n_d     = n_q;
        cnt_d   = cnt_q;
        sat_d   = sat_q;
        i_d     = i_q;
        q_d     = q_q;
        acc_clr = 1'b0;
        accept  = 1'b0;
        case (state_q)
            IDLE: begin
                if (Meas_start && (N_samples != '0)) begin
                    state_d = ACUM;
                    n_d     = N_samples;
                    cnt_d   = '0;
                    sat_d   = 1'b0;
                    acc_clr = 1'b1;
                end
            end
            ACUM: begin
                // The count compare is on the registered counter, so the cycle after
                // the Nth sample lets stage 2 absorb it while nothing new is accepted.
                if (cnt_q == n_q) begin
                    state_d = DRAIN;
                end else if (Sample_valid) begin
                    accept = 1'b1;
                    cnt_d  = cnt_q + 1'b1;
                end
            end
            DRAIN: begin
                state_d = ESCALA;
            end
            ESCALA: begin
                i_d     = {{(OUT_W-SAT_W){sat_i.val[SAT_W-1]}}, sat_i.val};
                q_d     = {{(OUT_W-SAT_W){sat_q_ch.val[SAT_W-1]}}, sat_q_ch.val};
                sat_d   = sat_q | sat_i.clip | sat_q_ch.clip;
                state_d = LANZA;
            end
            LANZA: begin
                if (Atan_done) begin
                    state_d = FIN;
                end
            end
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RSTa) begin
        if (!RSTa) begin
            state_q <= IDLE;
            n_q     <= '0;
            cnt_q   <= '0;
            sat_q   <= 1'b0;
            i_q     <= '0;
            q_q     <= '0;
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
            cnt_q   <= cnt_d;
            sat_q   <= sat_d;
            i_q     <= i_d;
            q_q     <= q_d;
        end
    end

    // Handshake outputs decode the state register directly so reset drops them at once.
    assign Atan_start = (state_q == LANZA);
    assign Busy       = (state_q != IDLE);
    assign Ready      = (state_q == FIN);
    assign Sat        = sat_q;
    assign I_out      = i_q;
    assign Q_out      = q_q;

endmodule

// File: tb/tb_iq_acumulador.sv
// Self-checking bench for iq_acumulador: randomized and directed measurements against
// a sum/floor-divide/clamp reference model, plus handshake and reset-abort checks.
module tb_iq_acumulador;

    logic               CLK;
    logic               RSTa;
    logic               Meas_start;
    logic [15:0]        N_samples;
    logic               Sample_valid;
    logic signed [13:0] Adc;
    logic signed [15:0] Ref_sin;
    logic signed [15:0] Ref_cos;
    logic               Atan_done;
    logic signed [31:0] Q_out;
    logic signed [31:0] I_out;
    logic               Atan_start;
    logic               Busy;
    logic               Ready;
    logic               Sat;

    int n_checks = 0;
    int n_fail   = 0;

    iq_acumulador dut (
        .CLK          (CLK),
        .RSTa         (RSTa),
        .Meas_start   (Meas_start),
        .N_samples    (N_samples),
        .Sample_valid (Sample_valid),
        .Adc          (Adc),
        .Ref_sin      (Ref_sin),
        .Ref_cos      (Ref_cos),
        .Atan_done    (Atan_done),
        .Q_out        (Q_out),
        .I_out        (I_out),
        .Atan_start   (Atan_start),
        .Busy         (Busy),
        .Ready        (Ready),
        .Sat          (Sat)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #5_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Reference scaling: floor(sum / 2^16), clamped to the signed 26-bit range.
    function automatic longint scale(input longint s, output bit clip);
        longint q;
        q = s / 65536;
        if ((s < 0) && (q * 65536 != s)) q = q - 1;
        clip = 1'b0;
        if (q > 33554431) begin
            q = 33554431;
            clip = 1'b1;
        end else if (q < -33554432) begin
            q = -33554432;
            clip = 1'b1;
        end
        return q;
    endfunction

    task automatic abort_reset(input string tag);
        #2 RSTa = 1'b0;
        #1;
        chk({tag, "_atan_start"}, Atan_start, 0);
        chk({tag, "_busy"}, Busy, 0);
        chk({tag, "_ready"}, Ready, 0);
        chk({tag, "_sat"}, Sat, 0);
        chk({tag, "_i_out"}, I_out, 0);
        chk({tag, "_q_out"}, Q_out, 0);
        Sample_valid = 1'b0;
        Meas_start   = 1'b0;
        Atan_done    = 1'b0;
        #2 RSTa = 1'b1;
    endtask

    // mode: 0 contiguous fixed data, 1 fixed data on valid pattern 1,0,0,1,0,1, 2 random
    // abort_at: 0 none, 1 reset after 3 accepted samples, 2 reset while in LANZA
    task automatic do_meas(input int n, input int mode, input int a0, input int c0,
                           input int s0, input int dly, input int abort_at);
        longint             si, sq, ei, eq;
        bit                 ci, cq, v;
        int                 idx, cyc, lat, hs, rdy, guard;
        logic signed [13:0] a;
        logic signed [15:0] c, s;
        bit [5:0]           pat;
        pat = 6'b101001;
        si = 0;
        sq = 0;
        @(posedge CLK); #1;
        Meas_start   = 1'b1;
        N_samples    = 16'(n);
        Sample_valid = 1'b0;
        @(posedge CLK); #1;
        Meas_start = 1'b0;
        chk("busy_after_start", Busy, 1);
        idx = 0;
        cyc = 0;
        while ((idx < n) && (cyc < 70000)) begin
            a = 14'($urandom);
            c = 16'($urandom);
            s = 16'($urandom);
            case (mode)
                0:       v = 1'b1;
                1:       v = pat[cyc % 6];
                default: v = ($urandom_range(0, 99) >= 30);
            endcase
            if (v && (mode != 2)) begin
                a = 14'(a0);
                c = 16'(c0);
                s = 16'(s0);
            end
            Sample_valid = v;
            Adc          = a;
            Ref_cos      = c;
            Ref_sin      = s;
            Meas_start   = (mode == 0) ? 1'b0 : 1'($urandom_range(0, 1));
            N_samples    = 16'($urandom);
            @(posedge CLK); #1;
            if (v) begin
                si += longint'(a) * longint'(c);
                sq += longint'(a) * longint'(s);
                idx++;
            end
            cyc++;
            if ((abort_at == 1) && (idx == 3)) begin
                abort_reset("abort_acum");
                return;
            end
        end
        chk("samples_fed", idx, n);
        Meas_start   = 1'b0;
        Sample_valid = 1'b1;
        Adc          = 14'($urandom);
        Ref_cos      = 16'($urandom);
        Ref_sin      = 16'($urandom);
        // The cycle that presented the Nth sample counts as 1.
        lat = 1;
        while (!Atan_start && (lat < 20)) begin
            @(posedge CLK); #1;
            lat++;
        end
        Sample_valid = 1'b0;
        chk("start_latency", lat, 4);
        ei = scale(si, ci);
        eq = scale(sq, cq);
        chk("i_out", I_out, ei);
        chk("q_out", Q_out, eq);
        chk("sat", Sat, longint'(ci | cq));
        chk("busy_lanza", Busy, 1);
        if (abort_at == 2) begin
            repeat (2) @(posedge CLK);
            #1;
            chk("lanza_held", Atan_start, 1);
            abort_reset("abort_lanza");
            return;
        end
        hs = 0;
        rdy = 0;
        guard = 0;
        while (guard < dly + 20) begin
            if (Atan_start) hs++;
            Atan_done = Atan_start && (hs == dly);
            @(posedge CLK); #1;
            guard++;
            if (Ready) begin
                rdy++;
                chk("busy_with_ready", Busy, 1);
                chk("start_low_after_done", Atan_start, 0);
            end else if (rdy > 0) begin
                break;
            end
        end
        Atan_done = 1'b0;
        chk("start_high_cycles", hs, dly);
        chk("ready_pulses", rdy, 1);
        chk("busy_falls_with_ready", Busy, 0);
        chk("i_out_hold", I_out, ei);
        chk("q_out_hold", Q_out, eq);
        chk("sat_hold", Sat, longint'(ci | cq));
    endtask

    initial begin
        RSTa         = 1'b0;
        Meas_start   = 1'b0;
        N_samples    = '0;
        Sample_valid = 1'b0;
        Adc          = '0;
        Ref_sin      = '0;
        Ref_cos      = '0;
        Atan_done    = 1'b0;
        #12;
        chk("rst_i_out", I_out, 0);
        chk("rst_q_out", Q_out, 0);
        chk("rst_atan_start", Atan_start, 0);
        chk("rst_busy", Busy, 0);
        chk("rst_ready", Ready, 0);
        chk("rst_sat", Sat, 0);
        #11 RSTa = 1'b1;

        do_meas(4, 0, 1000, 16384, 0, 40, 0);
        do_meas(3, 1, 100, 16384, 0, 5, 0);

        @(posedge CLK); #1;
        Meas_start = 1'b1;
        N_samples  = 16'd0;
        repeat (3) @(posedge CLK);
        #1;
        chk("zero_n_busy", Busy, 0);
        chk("zero_n_start", Atan_start, 0);
        Meas_start = 1'b0;

        for (int k = 0; k < 6; k++) begin
            do_meas($urandom_range(1, 20), 2, 0, 0, 0, $urandom_range(1, 12), 0);
        end

        do_meas(10, 2, 0, 0, 0, 4, 1);
        do_meas($urandom_range(4, 15), 2, 0, 0, 0, 6, 0);
        do_meas(5, 2, 0, 0, 0, 4, 2);
        do_meas($urandom_range(4, 15), 2, 0, 0, 0, 3, 0);

        do_meas(65535, 0, -8192, -32768, 32767, 3, 0);
        chk("sat_i_bound", I_out, 33554431);
        chk("sat_q_bound", Q_out, -33554432);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/iq_acumulador.md
Name: iq_acumulador

Overview:
- Lock-in demodulation front end directly upstream of the arctan2 phase divider.
- Multiplies each ADC sample by the in-phase and quadrature reference samples and accumulates over a programmed number of samples.
- Scales and saturates the two sums into I (denominator) and Q (numerator) words.
- Runs the Start/Done handshake with the arctan2 stage and flags when the phase measurement is complete.

Parameters:
- ADC_W, 14, signed ADC sample width
- REF_W, 16, signed reference sine/cosine width
- ACC_W, 48, signed accumulator width
- N_W, 16, sample-count width
- SHIFT, 16, arithmetic right shift applied to accumulators before output
- OUT_W, 32, output word width; equals the arctan2 tamanyo
- SAT_W, 26, signed saturation range of outputs; the downstream stage shifts the numerator left by 6, so 26 + 6 = OUT_W

Ports:
- CLK  in  1  clock
- RSTa  in  1  asynchronous active-low reset
- Meas_start  in  1  level; sampled only in IDLE
- N_samples  in  N_W  unsigned number of samples to accumulate
- Sample_valid  in  1  qualifies Adc/Ref_sin/Ref_cos this cycle
- Adc  in  ADC_W  signed sample
- Ref_sin  in  REF_W  signed quadrature reference
- Ref_cos  in  REF_W  signed in-phase reference
- Atan_done  in  1  Done from the arctan2 stage
- Q_out  out  OUT_W  signed numerator, to arctan2 Num
- I_out  out  OUT_W  signed denominator, to arctan2 Den
- Atan_start  out  1  Start to the arctan2 stage
- Busy  out  1  high in every state except IDLE
- Ready  out  1  one-cycle pulse when the measurement is complete
- Sat  out  1  sticky saturation flag for the current measurement

Behaviour:
- Interface: one clock, CLK. Reset RSTa is asynchronous, active-low.
- Reset: all state registers, accumulators, counter and pipeline valid are cleared; state = IDLE. Q_out = 0, I_out = 0, Atan_start = 0, Busy = 0, Ready = 0, Sat = 0.
- Reset mid-operation aborts the measurement. Atan_start drops in the same instant, so arctan2 returns to its idle state.
- States:
  - IDLE -> ACUM when Meas_start = 1 and N_samples != 0. On this transition: latch N_samples, clear both accumulators, counter and Sat.
  - Meas_start with N_samples = 0 is ignored; the block stays in IDLE.
  - ACUM: 2-stage pipeline.
    - Stage 1 registers the full-precision products Adc*Ref_cos and Adc*Ref_sin (ADC_W+REF_W bits) plus a valid bit, when Sample_valid = 1.
    - Stage 2 sign-extends each product to ACC_W and adds it to its accumulator when stage-1 valid = 1.
    - Counter increments per accepted Sample_valid. Gaps in Sample_valid are allowed and simply stall counting.
    - When the counter reaches the latched N, stop accepting samples and go to DRAIN.
  - DRAIN (1 cycle): the last product enters the accumulators -> ESCALA.
  - ESCALA (1 cycle): arithmetic shift of each accumulator right by SHIFT.
    - Values above 2^(SAT_W-1)-1 or below -2^(SAT_W-1) clamp to that bound and set Sat.
    - Result is sign-extended to OUT_W and registered into I_out/Q_out -> LANZA.
  - LANZA: Atan_start = 1, held. I_out/Q_out stay frozen. When Atan_done = 1 -> FIN with Atan_start = 0 on the next cycle.
  - FIN (1 cycle): Ready = 1 -> IDLE.
- I_out/Q_out/Sat keep their values until the next accepted Meas_start.
- Latency from the Nth accepted sample to Atan_start = 1 is 4 cycles: stage 1, stage 2, DRAIN/ESCALA register.
- Meas_start while Busy = 1 is ignored. Sample_valid outside ACUM is ignored.
- Accumulators never wrap for N ≤ 2^N_W - 1 at full-scale inputs: 29 + 16 bits < 48.

Decomposition:
- Package iq_pkg:
  - state enum {IDLE, ACUM, DRAIN, ESCALA, LANZA, FIN}
  - default width localparams
  - saturate function (ACC_W -> SAT_W, returns clip flag)
- Sub-module mac_canal: 2-stage multiply-accumulate with clear and enable, instantiated twice (cos -> I, sin -> Q).
- FSM, counter, scaling and handshake live in iq_acumulador.

Test Plan:
- Adc = 1000, Ref_cos = 16384, Ref_sin = 0, N = 4, contiguous valid -> I_out = 1000, Q_out = 0, Sat = 0. Atan_start rises 4 cycles after the 4th sample.
- Adc = -8192, Ref_cos = -32768, Ref_sin = 32767, N = 65535 -> I_out = 33554431, Q_out = -33554432 (0xFE000000), Sat = 1.
- Atan_done stub returns 40 cycles after Atan_start -> Atan_start high exactly 40 cycles, low the cycle after Done, Ready pulses once, Busy falls with Ready.
- N = 3, Sample_valid toggled 1,0,0,1,0,1 with Adc = 100, Ref_cos = 65536>>2 = 16384 -> only 3 samples summed: I_out = 75 (4,915,200 >> 16). Meas_start pulses during ACUM have no effect.
- N_samples = 0 with Meas_start = 1 -> stays IDLE, Busy = 0. RSTa low mid-ACUM or mid-LANZA -> all outputs 0 asynchronously, a new measurement afterwards completes correctly.
